// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder: stage limit, op encoding
// and the segment-width helper.
package cla_pkg;

  localparam int CLA_MAX_STAGES = 8;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int seg_width(input int width, input int stages);
    return (stages > 0) ? (width / stages) : width;
  endfunction

endpackage

// File: rtl/cla_segment.sv
// Combinational SEG-bit carry-lookahead slice; every carry is formed directly from the
// generate/propagate terms rather than rippling bit to bit.
module cla_segment
  import cla_pkg::*;
#(
  parameter int SEG = 16
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout
);

  logic [SEG-1:0] gen;
  logic [SEG-1:0] prop;
  logic [SEG:0]   carry;

  assign gen  = a & b;
  assign prop = a ^ b;

  // c[i+1] = g[i] | p[i]g[i-1] | p[i]p[i-1]g[i-2] | ... | p[i..0]cin
  always_comb begin
    logic acc;
    logic run;
    carry    = '0;
    acc      = 1'b0;
    run      = 1'b0;
    carry[0] = cin;
    for (int i = 0; i < SEG; i++) begin
      acc = gen[i];
      run = prop[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (run & gen[j]);
        run = run & prop[j];
      end
      carry[i+1] = acc | (run & cin);
    end
  end

  assign sum  = prop ^ carry[SEG-1:0];
  assign cout = carry[SEG];

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined CLA add/subtract with valid/ready backpressure: one segment per stage,
// carry passed rank to rank. Optional out_overflow port under CLA_PIPE_OVERFLOW_EN.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_op_sub,
  input  logic             in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum
`ifdef CLA_PIPE_OVERFLOW_EN
  ,
  output logic             out_overflow
`endif
);

  localparam int SEG = seg_width(WIDTH, STAGES);

  if ((STAGES < 1) || (STAGES > CLA_MAX_STAGES) || ((WIDTH % STAGES) != 0)) begin : g_param_check
    $error("cla_pipe_adder: WIDTH must divide evenly into 1..8 STAGES");
  end

  // Rank 0 holds the operands as they will be added (B already inverted for subtract);
  // rank k holds the low k segments of the result plus the carry out of segment k-1.
  logic                   valid_q [0:STAGES];
  logic                   c_q     [0:STAGES];
  logic [WIDTH-1:0]       a_q     [0:STAGES-1];
  logic [WIDTH-1:0]       b_q     [0:STAGES-1];
  logic [WIDTH-1:0]       sum_q   [1:STAGES];
  logic [WIDTH-1:0]       sum_d   [1:STAGES];

  logic [STAGES-1:0][SEG-1:0] seg_sum;
  logic [STAGES-1:0]          seg_cout;
  logic                       advance;

  assign advance  = !valid_q[STAGES] || out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    cla_segment #(.SEG(SEG)) u_seg (
      .a    (a_q[k][k*SEG +: SEG]),
      .b    (b_q[k][k*SEG +: SEG]),
      .cin  (c_q[k]),
      .sum  (seg_sum[k]),
      .cout (seg_cout[k])
    );
  end

  always_comb begin
    for (int k = 1; k <= STAGES; k++) begin
      sum_d[k] = '0;
    end
    sum_d[1][SEG-1:0] = seg_sum[0];
    for (int k = 2; k <= STAGES; k++) begin
      sum_d[k]                   = sum_q[k-1];
      sum_d[k][(k-1)*SEG +: SEG] = seg_sum[k-1];
    end
  end

`ifdef CLA_PIPE_OVERFLOW_EN
  logic ovf_q;
  logic ovf_d;

  // The carry into the MSB is recovered from the MSB sum bit and its two operand bits.
  assign ovf_d = seg_cout[STAGES-1] ^ (a_q[STAGES-1][WIDTH-1] ^ b_q[STAGES-1][WIDTH-1]
                                       ^ seg_sum[STAGES-1][SEG-1]);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
    end else if (advance) begin
      ovf_q <= ovf_d;
    end
  end

  assign out_overflow = ovf_q;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k <= STAGES; k++) begin
        valid_q[k] <= 1'b0;
        c_q[k]     <= 1'b0;
      end
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
      for (int k = 1; k <= STAGES; k++) begin
        sum_q[k] <= '0;
      end
    end else if (advance) begin
      valid_q[0] <= in_valid;
      a_q[0]     <= in_a;
      b_q[0]     <= (in_op_sub == OP_SUB) ? ~in_b : in_b;
      c_q[0]     <= (in_op_sub == OP_SUB) ? ~in_carry : in_carry;
      for (int k = 1; k <= STAGES; k++) begin
        valid_q[k] <= valid_q[k-1];
        c_q[k]     <= seg_cout[k-1];
        sum_q[k]   <= sum_d[k];
      end
      for (int k = 1; k < STAGES; k++) begin
        a_q[k] <= a_q[k-1];
        b_q[k] <= b_q[k-1];
      end
    end
  end

  assign out_valid = valid_q[STAGES];
  assign out_sum   = {c_q[STAGES], sum_q[STAGES]};

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder (64/4 main instance, plus 32/1 and 24/8);
// build with CLA_PIPE_OVERFLOW_EN defined to also exercise out_overflow.
module tb_cla_pipe_adder;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset_n;

  logic        in_valid, in_ready, in_op_sub, in_carry, out_valid, out_ready;
  logic [63:0] in_a, in_b;
  logic [64:0] out_sum;

  logic        p1_in_valid, p1_in_ready, p1_op_sub, p1_carry, p1_out_valid, p1_out_ready;
  logic [31:0] p1_a, p1_b;
  logic [32:0] p1_out_sum;

  logic        p2_in_valid, p2_in_ready, p2_op_sub, p2_carry, p2_out_valid, p2_out_ready;
  logic [23:0] p2_a, p2_b;
  logic [24:0] p2_out_sum;

`ifdef CLA_PIPE_OVERFLOW_EN
  logic out_overflow, p1_overflow, p2_overflow;
`endif

  int tests  = 0;
  int errors = 0;

  cla_pipe_adder #(.WIDTH(64), .STAGES(4)) u_dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_op_sub(in_op_sub), .in_carry(in_carry),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum)
`ifdef CLA_PIPE_OVERFLOW_EN
    , .out_overflow(out_overflow)
`endif
  );

  cla_pipe_adder #(.WIDTH(32), .STAGES(1)) u_dut_w32s1 (
    .clock(clock), .reset_n(reset_n),
    .in_valid(p1_in_valid), .in_ready(p1_in_ready), .in_a(p1_a), .in_b(p1_b),
    .in_op_sub(p1_op_sub), .in_carry(p1_carry),
    .out_valid(p1_out_valid), .out_ready(p1_out_ready), .out_sum(p1_out_sum)
`ifdef CLA_PIPE_OVERFLOW_EN
    , .out_overflow(p1_overflow)
`endif
  );

  cla_pipe_adder #(.WIDTH(24), .STAGES(8)) u_dut_w24s8 (
    .clock(clock), .reset_n(reset_n),
    .in_valid(p2_in_valid), .in_ready(p2_in_ready), .in_a(p2_a), .in_b(p2_b),
    .in_op_sub(p2_op_sub), .in_carry(p2_carry),
    .out_valid(p2_out_valid), .out_ready(p2_out_ready), .out_sum(p2_out_sum)
`ifdef CLA_PIPE_OVERFLOW_EN
    , .out_overflow(p2_overflow)
`endif
  );

  // Reference: add is A+B+cin; subtract is A-B-bin offset by 2^w, kept to w+1 bits.
  function automatic logic [64:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                        input logic sub, input logic cin);
    logic [65:0] t;
    logic [65:0] mask;
    if (!sub) t = {2'b00, a} + {2'b00, b} + {65'd0, cin};
    else      t = (66'd1 << w) + {2'b00, a} - {2'b00, b} - {65'd0, cin};
    mask = (66'd1 << (w + 1)) - 66'd1;
    t = t & mask;
    return t[64:0];
  endfunction

`ifdef CLA_PIPE_OVERFLOW_EN
  // Signed result out of range for a w-bit two's-complement word (w <= 32).
  function automatic bit model_ovf(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic sub, input logic cin);
    longint sa, sb, r, lim;
    lim = longint'(1) << (w - 1);
    sa  = longint'(a);
    sb  = longint'(b);
    if (a[w-1]) sa = sa - (lim << 1);
    if (b[w-1]) sb = sb - (lim << 1);
    r = sub ? (sa - sb - longint'(cin)) : (sa + sb + longint'(cin));
    return (r > lim - 1) || (r < -lim);
  endfunction
`endif

  function automatic logic [63:0] rand64();
    case ($urandom_range(0, 7))
      0:       return 64'hFFFF_FFFF_FFFF_FFFF;
      1:       return 64'd0;
      2:       return 64'h8000_0000_0000_0000;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic idle_main();
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_op_sub = 1'b0;
    in_carry  = 1'b0;
    out_ready = 1'b1;
  endtask

  // Drive one beat on the 64-bit instance and wait (bounded) for its result.
  task automatic send_one(input logic [63:0] a, input logic [63:0] b, input logic sub,
                          input logic cin, output logic [64:0] res, output bit got);
    got       = 1'b0;
    res       = '0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_op_sub = sub;
    in_carry  = cin;
    @(posedge clock); #1;
    idle_main();
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin
        got = 1'b1;
        res = out_sum;
        break;
      end
      @(posedge clock); #1;
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    int stale;
    reset_n = 1'b0;
    idle_main();
    repeat (2) @(posedge clock);
    #1;
    tests++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got=%b exp=0", out_valid); end
    tests++; if (out_sum !== 65'd0) begin errors++; $display("[TB] FAIL reset_out_sum got=%h exp=0", out_sum); end
    tests++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got=%b exp=1", in_ready); end
    reset_n = 1'b1;
    @(posedge clock); #1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_a     = rand64();
      in_b     = rand64();
      @(posedge clock); #1;
    end
    idle_main();
    #2;
    reset_n = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_out_valid got=%b exp=0", out_valid); end
    tests++; if (out_sum !== 65'd0) begin errors++; $display("[TB] FAIL midreset_out_sum got=%h exp=0", out_sum); end
    tests++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL midreset_in_ready got=%b exp=1", in_ready); end
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock);
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL release_state got out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready);
    end
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (out_valid) stale++;
    end
    tests++; if (stale != 0) begin errors++; $display("[TB] FAIL stale_beats got=%0d exp=0", stale); end
    @(posedge clock); #1;
  endtask

  task automatic test_latency();
    in_valid  = 1'b1;
    in_a      = 64'd5;
    in_b      = 64'd7;
    in_op_sub = 1'b0;
    in_carry  = 1'b0;
    out_ready = 1'b1;
    @(posedge clock); #1;
    idle_main();
    repeat (3) begin @(posedge clock); #1; end
    tests++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL latency_early got out_valid=%b exp=0", out_valid); end
    @(posedge clock); #1;
    tests++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL latency_valid got=%b exp=1", out_valid); end
    tests++; if (out_sum !== 65'd12) begin errors++; $display("[TB] FAIL latency_sum got=%h exp=%h", out_sum, 65'd12); end
    @(posedge clock); #1;
  endtask

  task automatic test_carry_chain();
    logic [64:0] res;
    bit got;
    send_one(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b1, res, got);
    tests++; if (!got || res !== 65'h1_0000_0000_0000_0000) begin
      errors++; $display("[TB] FAIL carry_ripple got=%h (seen=%0d) exp=%h", res, got, 65'h1_0000_0000_0000_0000);
    end
    send_one(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, res, got);
    tests++; if (!got || res !== 65'h1_FFFF_FFFF_FFFF_FFFF) begin
      errors++; $display("[TB] FAIL carry_allones got=%h (seen=%0d) exp=%h", res, got, 65'h1_FFFF_FFFF_FFFF_FFFF);
    end
  endtask

  task automatic test_sub_borrow();
    logic [64:0] res;
    bit got;
    send_one(64'd0, 64'd1, 1'b1, 1'b0, res, got);
    tests++; if (!got || res !== 65'h0_FFFF_FFFF_FFFF_FFFF) begin
      errors++; $display("[TB] FAIL sub_borrow got=%h (seen=%0d) exp=%h", res, got, 65'h0_FFFF_FFFF_FFFF_FFFF);
    end
    send_one(64'd9, 64'd4, 1'b1, 1'b0, res, got);
    tests++; if (!got || res !== {1'b1, 64'd5}) begin
      errors++; $display("[TB] FAIL sub_noborrow got=%h (seen=%0d) exp=%h", res, got, {1'b1, 64'd5});
    end
    send_one(64'd9, 64'd4, 1'b1, 1'b1, res, got);
    tests++; if (!got || res !== {1'b1, 64'd4}) begin
      errors++; $display("[TB] FAIL sub_borrowin got=%h (seen=%0d) exp=%h", res, got, {1'b1, 64'd4});
    end
  endtask

  // Phase 0: 10 beats with out_ready toggling; phase 1: 150 beats with random valid/ready.
  task automatic test_backpressure();
    logic [64:0] expq[$];
    logic [64:0] exp_v, held_sum;
    int sent, recv, nbeats, cyc;
    bit pend, was_stalled;
    for (int phase = 0; phase < 2; phase++) begin
      nbeats = (phase == 0) ? 10 : 150;
      sent = 0; recv = 0; cyc = 0; pend = 0; was_stalled = 0;
      expq.delete();
      while ((recv < nbeats) && (cyc < 2000)) begin
        if (!pend) begin
          if ((sent < nbeats) && (phase == 0 || $urandom_range(0, 3) != 0)) begin
            in_valid  = 1'b1;
            in_a      = rand64();
            in_b      = rand64();
            in_op_sub = 1'($urandom_range(0, 1));
            in_carry  = 1'($urandom_range(0, 1));
            pend      = 1'b1;
          end else begin
            in_valid = 1'b0;
          end
        end
        out_ready = (phase == 0) ? cyc[0] : 1'($urandom_range(0, 1));
        @(negedge clock);
        tests++;
        if (in_ready !== !(out_valid && !out_ready)) begin
          errors++; $display("[TB] FAIL in_ready_rule got=%b out_valid=%b out_ready=%b", in_ready, out_valid, out_ready);
        end
        if (was_stalled) begin
          tests++;
          if (out_valid !== 1'b1 || out_sum !== held_sum) begin
            errors++; $display("[TB] FAIL stall_hold got=%h/%b exp=%h/1", out_sum, out_valid, held_sum);
          end
        end
        was_stalled = out_valid && !out_ready;
        held_sum    = out_sum;
        if (out_valid && out_ready) begin
          tests++;
          if (expq.size() == 0) begin
            errors++; $display("[TB] FAIL stream_extra got=%h exp=none", out_sum);
          end else begin
            exp_v = expq.pop_front();
            if (out_sum !== exp_v) begin
              errors++; $display("[TB] FAIL stream_data beat=%0d got=%h exp=%h", recv, out_sum, exp_v);
            end
          end
          recv++;
        end
        if (in_valid && in_ready) begin
          expq.push_back(model(64, in_a, in_b, in_op_sub, in_carry));
          sent++;
          pend = 1'b0;
        end
        @(posedge clock); #1;
        cyc++;
      end
      idle_main();
      tests++;
      if (recv != nbeats || expq.size() != 0) begin
        errors++; $display("[TB] FAIL stream_count phase=%0d got=%0d exp=%0d left=%0d", phase, recv, nbeats, expq.size());
      end
      repeat (6) begin @(posedge clock); #1; end
    end
  endtask

  task automatic test_params();
    logic [64:0] q1[$], q2[$];
`ifdef CLA_PIPE_OVERFLOW_EN
    bit qo1[$];
    bit eo;
`endif
    logic [64:0] e;
    logic [31:0] r;
    int sent1, sent2, recv1, recv2, cyc;
    bit pend1, pend2;
    localparam int N = 120;
    sent1 = 0; sent2 = 0; recv1 = 0; recv2 = 0; cyc = 0; pend1 = 0; pend2 = 0;
    while (cyc < 3000 && (recv1 < N || recv2 < N)) begin
      if (!pend1) begin
        p1_in_valid = (sent1 < N) && ($urandom_range(0, 3) != 0);
        p1_a = $urandom; p1_b = $urandom;
        if ($urandom_range(0, 5) == 0) p1_a = 32'h7FFF_FFFF;
        p1_op_sub = 1'($urandom_range(0, 1));
        p1_carry  = 1'($urandom_range(0, 1));
        pend1 = p1_in_valid;
      end
      if (!pend2) begin
        p2_in_valid = (sent2 < N) && ($urandom_range(0, 3) != 0);
        r = $urandom; p2_a = r[23:0];
        r = $urandom; p2_b = r[23:0];
        p2_op_sub = 1'($urandom_range(0, 1));
        p2_carry  = 1'($urandom_range(0, 1));
        pend2 = p2_in_valid;
      end
      p1_out_ready = 1'($urandom_range(0, 1));
      p2_out_ready = 1'($urandom_range(0, 1));
      @(negedge clock);
      if (p1_out_valid && p1_out_ready) begin
        tests++;
        e = (q1.size() != 0) ? q1.pop_front() : 65'h1_DEAD_BEEF_DEAD_BEEF;
        if ({32'd0, p1_out_sum} !== e) begin
          errors++; $display("[TB] FAIL w32s1_data beat=%0d got=%h exp=%h", recv1, p1_out_sum, e);
        end
`ifdef CLA_PIPE_OVERFLOW_EN
        tests++;
        eo = (qo1.size() != 0) ? qo1.pop_front() : 1'b0;
        if (p1_overflow !== eo) begin
          errors++; $display("[TB] FAIL w32s1_ovf beat=%0d got=%b exp=%b", recv1, p1_overflow, eo);
        end
`endif
        recv1++;
      end
      if (p2_out_valid && p2_out_ready) begin
        tests++;
        e = (q2.size() != 0) ? q2.pop_front() : 65'h1_DEAD_BEEF_DEAD_BEEF;
        if ({40'd0, p2_out_sum} !== e) begin
          errors++; $display("[TB] FAIL w24s8_data beat=%0d got=%h exp=%h", recv2, p2_out_sum, e);
        end
        recv2++;
      end
      if (p1_in_valid && p1_in_ready) begin
        q1.push_back(model(32, {32'd0, p1_a}, {32'd0, p1_b}, p1_op_sub, p1_carry));
`ifdef CLA_PIPE_OVERFLOW_EN
        qo1.push_back(model_ovf(32, p1_a, p1_b, p1_op_sub, p1_carry));
`endif
        sent1++; pend1 = 0;
      end
      if (p2_in_valid && p2_in_ready) begin
        q2.push_back(model(24, {40'd0, p2_a}, {40'd0, p2_b}, p2_op_sub, p2_carry));
        sent2++; pend2 = 0;
      end
      @(posedge clock); #1;
      cyc++;
    end
    p1_in_valid = 1'b0; p2_in_valid = 1'b0;
    p1_out_ready = 1'b1; p2_out_ready = 1'b1;
    tests++;
    if (recv1 != N || q1.size() != 0) begin
      errors++; $display("[TB] FAIL w32s1_count got=%0d exp=%0d", recv1, N);
    end
    tests++;
    if (recv2 != N || q2.size() != 0) begin
      errors++; $display("[TB] FAIL w24s8_count got=%0d exp=%0d", recv2, N);
    end
    repeat (10) begin @(posedge clock); #1; end
  endtask

`ifdef CLA_PIPE_OVERFLOW_EN
  task automatic test_overflow();
    bit got;
    p1_out_ready = 1'b1;
    p1_in_valid  = 1'b1;
    p1_a = 32'h7FFF_FFFF; p1_b = 32'd1; p1_op_sub = 1'b0; p1_carry = 1'b0;
    @(posedge clock); #1;
    p1_in_valid = 1'b0;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (p1_out_valid) begin
        got = 1;
        tests++;
        if (p1_overflow !== 1'b1 || p1_out_sum !== 33'h0_8000_0000) begin
          errors++; $display("[TB] FAIL ovf_max_plus1 got ovf=%b sum=%h exp 1/%h", p1_overflow, p1_out_sum, 33'h0_8000_0000);
        end
      end else begin
        @(posedge clock); #1;
      end
    end
    if (!got) begin
      tests++; errors++; $display("[TB] FAIL ovf_timeout got=no result exp=one result");
    end
    @(posedge clock); #1;
  endtask
`endif

  initial begin
    p1_in_valid = 1'b0; p1_a = '0; p1_b = '0; p1_op_sub = 1'b0; p1_carry = 1'b0; p1_out_ready = 1'b1;
    p2_in_valid = 1'b0; p2_a = '0; p2_b = '0; p2_op_sub = 1'b0; p2_carry = 1'b0; p2_out_ready = 1'b1;
    test_reset();
    test_latency();
    test_carry_chain();
    test_sub_borrow();
    test_backpressure();
    test_params();
`ifdef CLA_PIPE_OVERFLOW_EN
    test_overflow();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
